pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Scoreboard-based hazard and forwarding controller for the 5-stage pipelined CPU. It shadows the ID/EX, EX/MEM and MEM/WB pipeline registers with per-instruction metadata: valid, destination, load flag and source operands. From that metadata it drives three kinds of output:
- stall and bubble signals for the PC, IF/ID and ID/EX registers;
- flush signals for a taken branch resolved in MEM;
- ALU operand forwarding selects for the EX stage.

The block generalises the hazard-free pipeline by adding parametrised register-address width, optional forwarding, and stall/flush performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- id_valid_i  input  1  an instruction occupies IF/ID.
- id_rs_i  input  REG_ADDR_W  ID-stage rs address.
- id_rt_i  input  REG_ADDR_W  ID-stage rt address.
- id_use_rs_i  input  1  ID instruction reads rs.
- id_use_rt_i  input  1  ID instruction reads rt.
- id_wr_i  input  1  ID instruction writes a register (RegWrite).
- id_rd_i  input  REG_ADDR_W  ID destination after the RegDst mux.
- id_load_i  input  1  ID instruction is a load (MemRead).
- br_taken_i  input  1  Branch & zero from EX/MEM: taken branch in MEM.
- stall_o  output  1  hold PC and IF/ID.
- bubble_o  output  1  zero the control fields entering ID/EX.
- flush_o  output  1  squash IF/ID, ID/EX and the EX/MEM load.
- fwd_a_o  output  2  EX operand A source: 00 register file, 01 MEM/WB, 10 EX/MEM.
- fwd_b_o  output  2  EX operand B source, same encoding as fwd_a_o.
- stall_cnt_o  output  CNT_W  number of stall cycles, saturating.
- flush_cnt_o  output  CNT_W  number of flush events, saturating.

## Operation
- Internal shadow stages:
  - S_EX, mirroring ID/EX: valid, wr, rd, load, rs, rt, use_rs, use_rt.
  - S_MEM, mirroring EX/MEM: valid, wr, rd, load.
  - S_WB, mirroring MEM/WB: valid, wr, rd.
- A "writer match on r" is: stage valid & wr & rd == r & r != 0. Register 0 never matches.
- Source match: (id_use_rs_i & match on id_rs_i) | (id_use_rt_i & match on id_rt_i), qualified by id_valid_i.
- Stall with forwarding: S_EX is a valid load with a source match (load-use, 1 cycle).
- Stall without forwarding: a source match in any of S_EX, S_MEM or S_WB. The register file writes on the clock edge, so a WB-stage writer still stalls.
- flush_o = br_taken_i.
- bubble_o = stall_o | flush_o.
- Flush has priority: when flush_o is high, stall_o is forced to 0.
- Forwarding for the instruction in S_EX (operand A shown; B is identical using rt/use_rt):
  - 10 if use_rs and S_MEM matches rs and S_MEM is not a load;
  - else 01 if S_WB matches rs;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- Shadow update on each clock edge:
  - S_WB <= S_MEM.
  - S_MEM <= flush ? invalid : S_EX.
  - S_EX <= (bubble | !id_valid_i) ? invalid : ID inputs.
- Counters:
  - stall_cnt_o increments on every cycle with stall_o high.
  - flush_cnt_o increments on every cycle with flush_o high.
  - Both saturate at all-ones and never wrap.

## Timing
- stall_o, bubble_o, flush_o and fwd_*_o are combinational from current inputs and shadow state; there is zero-cycle latency to the pipeline registers.
- Load-use with forwarding: exactly 1 stall cycle. The dependent instruction then receives fwd = 01 in EX.
- Without forwarding, a dependence on the instruction immediately ahead stalls 3 cycles.
- Reset (rst_i low at a clock edge):
  - all shadow stages become invalid;
  - counters become 0.
- While rst_i is low, all outputs are forced to 0: stall, bubble, flush, fwd = 00. br_taken_i is ignored.
- Reset mid-stall: the next cycle after release starts from an empty scoreboard, with no residual stall.
- A branch taken simultaneously with a load-use condition results in a flush only: no stall is counted, and flush_cnt_o increments.

## Configuration
- HAZ_FWD_EN defined:
  - forwarding logic is compiled in;
  - only load-use stalls occur.
- HAZ_FWD_EN undefined:
  - fwd_a_o and fwd_b_o are tied to 00;
  - stalls cover every RAW dependence until the writer leaves S_WB;
  - all other behaviour is identical.

## Test plan
- Reset: hold rst_i=0 for 3 cycles with br_taken_i=1 -> all outputs 0, counters 0.
- With HAZ_FWD_EN: lw r2 followed by add r3,r2,r4:
  - stall_o=1 and bubble_o=1 for exactly 1 cycle;
  - the add then sees fwd_a_o=01;
  - stall_cnt_o=1.
- With HAZ_FWD_EN: add r5,r1,r1; sub r6,r5,r5; or r7,r5,r0:
  - sub sees fwd_a_o=fwd_b_o=10;
  - or sees fwd_a_o=01, fwd_b_o=00;
  - no stall.
- Writes to r0 followed by a reader of r0 -> no stall, fwd 00, under both configurations.
- br_taken_i=1 for one cycle while a load-use condition is present:
  - flush_o=1, stall_o=0;
  - S_EX and S_MEM are invalid on the next cycle;
  - flush_cnt_o increments by 1.
- Without HAZ_FWD_EN: add r2 followed immediately by add r3,r2,r2 -> stall_o high for 3 consecutive cycles, stall_cnt_o=3.
- Counter saturation: with CNT_W=4, hold the stall condition for 20 cycles -> stall_cnt_o stays at 15.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Scoreboard hazard/forwarding controller for a 5-stage pipeline; outputs are combinational (0-cycle), shadow state updates each edge.
// Backpressure: stall_o holds PC and IF/ID; bubble_o/flush_o squash. Optional forwarding is compiled in with `define HAZ_FWD_EN.
module pipe_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_use_rs_i,
    input  logic                  id_use_rt_i,
    input  logic                  id_wr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_load_i,
    input  logic                  br_taken_i,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic                  flush_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [REG_ADDR_W-1:0] rd;
        logic                  load;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
    } ex_t;

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [REG_ADDR_W-1:0] rd;
        logic                  load;
    } mem_t;

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [REG_ADDR_W-1:0] rd;
    } wb_t;

    ex_t              r_ex;
    mem_t             r_mem;
    wb_t              r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_hit_ex;
    logic       w_hit_mem;
    logic       w_hit_wb;
    logic       w_stall_raw;
    logic       w_stall;
    logic       w_flush;
    logic       w_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Register 0 is hardwired, so a write to it is never a producer.
    function automatic logic f_match(input logic vld, input logic wr,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] r);
        return vld & wr & (rd == r) & (r != '0);
    endfunction

    assign w_hit_ex  = id_valid_i &
                       ((id_use_rs_i & f_match(r_ex.vld, r_ex.wr, r_ex.rd, id_rs_i)) |
                        (id_use_rt_i & f_match(r_ex.vld, r_ex.wr, r_ex.rd, id_rt_i)));
    assign w_hit_mem = id_valid_i &
                       ((id_use_rs_i & f_match(r_mem.vld, r_mem.wr, r_mem.rd, id_rs_i)) |
                        (id_use_rt_i & f_match(r_mem.vld, r_mem.wr, r_mem.rd, id_rt_i)));
    assign w_hit_wb  = id_valid_i &
                       ((id_use_rs_i & f_match(r_wb.vld, r_wb.wr, r_wb.rd, id_rs_i)) |
                        (id_use_rt_i & f_match(r_wb.vld, r_wb.wr, r_wb.rd, id_rt_i)));

`ifdef HAZ_FWD_EN
    assign w_stall_raw = w_hit_ex & r_ex.load;

    // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_ex.use_rs && !r_mem.load && f_match(r_mem.vld, r_mem.wr, r_mem.rd, r_ex.rs))
            w_fwd_a = 2'b10;
        else if (r_ex.use_rs && f_match(r_wb.vld, r_wb.wr, r_wb.rd, r_ex.rs))
            w_fwd_a = 2'b01;
        if (r_ex.use_rt && !r_mem.load && f_match(r_mem.vld, r_mem.wr, r_mem.rd, r_ex.rt))
            w_fwd_b = 2'b10;
        else if (r_ex.use_rt && f_match(r_wb.vld, r_wb.wr, r_wb.rd, r_ex.rt))
            w_fwd_b = 2'b01;
    end
`else
    // The register file writes on the edge, so a WB-stage producer still blocks.
    assign w_stall_raw = w_hit_ex | w_hit_mem | w_hit_wb;
    assign w_fwd_a     = 2'b00;
    assign w_fwd_b     = 2'b00;

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{r_ex.rs, r_ex.rt, r_ex.use_rs, r_ex.use_rt, r_mem.load};
`endif

    assign w_flush  = rst_i & br_taken_i;
    assign w_stall  = rst_i & w_stall_raw & ~w_flush;
    assign w_bubble = w_stall | w_flush;

    assign stall_o     = w_stall;
    assign bubble_o    = w_bubble;
    assign flush_o     = w_flush;
    assign fwd_a_o     = rst_i ? w_fwd_a : 2'b00;
    assign fwd_b_o     = rst_i ? w_fwd_b : 2'b00;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_wb.vld <= r_mem.vld;
            r_wb.wr  <= r_mem.wr;
            r_wb.rd  <= r_mem.rd;

            if (w_flush) begin
                r_mem <= '0;
            end else begin
                r_mem.vld  <= r_ex.vld;
                r_mem.wr   <= r_ex.wr;
                r_mem.rd   <= r_ex.rd;
                r_mem.load <= r_ex.load;
            end

            if (w_bubble || !id_valid_i) begin
                r_ex <= '0;
            end else begin
                r_ex.vld    <= 1'b1;
                r_ex.wr     <= id_wr_i;
                r_ex.rd     <= id_rd_i;
                r_ex.load   <= id_load_i;
                r_ex.rs     <= id_rs_i;
                r_ex.rt     <= id_rt_i;
                r_ex.use_rs <= id_use_rs_i;
                r_ex.use_rt <= id_use_rt_i;
            end

            if (w_stall && r_stall_cnt != {CNT_W{1'b1}})
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && r_flush_cnt != {CNT_W{1'b1}})
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit; expectations follow the HAZ_FWD_EN setting of the build.
module tb_pipe_hazard_unit;

`ifdef HAZ_FWD_EN
    localparam int         LU_STALLS = 1;
    localparam int         RAW_STALLS = 0;
    localparam logic [1:0] EXP_10 = 2'b10;
    localparam logic [1:0] EXP_01 = 2'b01;
`else
    localparam int         LU_STALLS = 3;
    localparam int         RAW_STALLS = 3;
    localparam logic [1:0] EXP_10 = 2'b00;
    localparam logic [1:0] EXP_01 = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        id_use_rs_i, id_use_rt_i, id_wr_i, id_load_i;
    logic        br_taken_i;
    logic        stall_o, bubble_o, flush_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;
    logic        sat_unused_stall, sat_unused_bubble, sat_unused_flush;
    logic [1:0]  sat_unused_fwd_a, sat_unused_fwd_b;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i),
        .id_use_rt_i(id_use_rt_i), .id_wr_i(id_wr_i), .id_rd_i(id_rd_i),
        .id_load_i(id_load_i), .br_taken_i(br_taken_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_hazard_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i),
        .id_use_rt_i(id_use_rt_i), .id_wr_i(id_wr_i), .id_rd_i(id_rd_i),
        .id_load_i(id_load_i), .br_taken_i(br_taken_i),
        .stall_o(sat_unused_stall), .bubble_o(sat_unused_bubble), .flush_o(sat_unused_flush),
        .fwd_a_o(sat_unused_fwd_a), .fwd_b_o(sat_unused_fwd_b),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id;
        id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_use_rs_i = 1'b0;
        id_use_rt_i = 1'b0; id_wr_i = 1'b0; id_rd_i = '0; id_load_i = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic wr, input logic [4:0] rd, input logic ld);
        id_valid_i = 1'b1; id_rs_i = rs; id_rt_i = rt; id_use_rs_i = urs;
        id_use_rt_i = urt; id_wr_i = wr; id_rd_i = rd; id_load_i = ld;
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        while (stall_o === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) begin
            checks++; failures++;
            $display("FAIL stall_timeout got=%0d cycles exp<10", n);
        end
    endtask

    // Drive one instruction into ID, hold it through any stall, then let it enter EX.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic wr, input logic [4:0] rd,
                         input logic ld, output int n);
        set_id(rs, rt, urs, urt, wr, rd, ld);
        #1;
        wait_stall(n);
        tick();
        idle_id();
        #1;
    endtask

    task automatic do_reset;
        rst_i = 1'b0; br_taken_i = 1'b0; idle_id();
        tick(); tick();
        rst_i = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b0; br_taken_i = 1'b1;
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
            checks++; if (bubble_o !== 1'b0) begin failures++; $display("FAIL rst_bubble got=%b exp=0", bubble_o); end
            checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush_o); end
            checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL rst_fwd got=%b/%b exp=00/00", fwd_a_o, fwd_b_o); end
        end
        checks++; if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
        br_taken_i = 1'b0; idle_id();
        rst_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0 || flush_o !== 1'b0) begin failures++; $display("FAIL rst_release got=%b/%b exp=0/0", stall_o, flush_o); end
    endtask

    task automatic test_load_use;
        int n;
        do_reset();
        issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, n);
        set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b1 || bubble_o !== 1'b1) begin failures++; $display("FAIL lu_first got=%b/%b exp=1/1", stall_o, bubble_o); end
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL lu_flush got=%b exp=0", flush_o); end
        wait_stall(n);
        checks++; if (n !== LU_STALLS) begin failures++; $display("FAIL lu_len got=%0d exp=%0d", n, LU_STALLS); end
        tick(); idle_id(); #1;
        checks++; if (fwd_a_o !== EXP_01) begin failures++; $display("FAIL lu_fwd_a got=%b exp=%b", fwd_a_o, EXP_01); end
        checks++; if (fwd_b_o !== 2'b00) begin failures++; $display("FAIL lu_fwd_b got=%b exp=00", fwd_b_o); end
        checks++; if (stall_cnt_o !== 16'(LU_STALLS)) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt_o, LU_STALLS); end
    endtask

    task automatic test_forwarding;
        int n;
        do_reset();
        issue(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, n);
        issue(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, n);
        checks++; if (n !== RAW_STALLS) begin failures++; $display("FAIL fw_sub_stall got=%0d exp=%0d", n, RAW_STALLS); end
        checks++; if (fwd_a_o !== EXP_10 || fwd_b_o !== EXP_10) begin failures++; $display("FAIL fw_sub got=%b/%b exp=%b/%b", fwd_a_o, fwd_b_o, EXP_10, EXP_10); end
        issue(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, n);
        checks++; if (n !== 0) begin failures++; $display("FAIL fw_or_stall got=%0d exp=0", n); end
        checks++; if (fwd_a_o !== EXP_01 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL fw_or got=%b/%b exp=%b/00", fwd_a_o, fwd_b_o, EXP_01); end
        checks++; if (stall_cnt_o !== 16'(RAW_STALLS)) begin failures++; $display("FAIL fw_cnt got=%0d exp=%0d", stall_cnt_o, RAW_STALLS); end
    endtask

    task automatic test_r0;
        int n;
        do_reset();
        issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, n);
        issue(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, n);
        checks++; if (n !== 0) begin failures++; $display("FAIL r0_load_stall got=%0d exp=0", n); end
        issue(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, n);
        checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL r0_fwd1 got=%b/%b exp=00/00", fwd_a_o, fwd_b_o); end
        issue(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, n);
        checks++; if (n !== 0) begin failures++; $display("FAIL r0_alu_stall got=%0d exp=0", n); end
        checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL r0_fwd2 got=%b/%b exp=00/00", fwd_a_o, fwd_b_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin failures++; $display("FAIL r0_cnt got=%0d exp=0", stall_cnt_o); end
    endtask

    task automatic test_branch;
        int n;
        do_reset();
        issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, n);
        set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
        br_taken_i = 1'b1;
        #1;
        checks++; if (flush_o !== 1'b1 || stall_o !== 1'b0 || bubble_o !== 1'b1) begin failures++; $display("FAIL br_out got=f%b s%b b%b exp=f1 s0 b1", flush_o, stall_o, bubble_o); end
        tick();
        br_taken_i = 1'b0;
        set_id(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0 || flush_o !== 1'b0) begin failures++; $display("FAIL br_after got=s%b f%b exp=s0 f0", stall_o, flush_o); end
        checks++; if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin failures++; $display("FAIL br_cnt got=%0d/%0d exp=1/0", flush_cnt_o, stall_cnt_o); end
        tick(); idle_id(); #1;
        checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL br_squash got=%b/%b exp=00/00", fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_reset_mid_stall;
        int n;
        do_reset();
        issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, n);
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", stall_o); end
        rst_i = 1'b0;
        tick();
        checks++; if (stall_o !== 1'b0 || bubble_o !== 1'b0) begin failures++; $display("FAIL mid_inrst got=%b/%b exp=0/0", stall_o, bubble_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0 || stall_cnt_o !== 16'd0) begin failures++; $display("FAIL mid_post got=%b cnt=%0d exp=0 cnt=0", stall_o, stall_cnt_o); end
        tick(); idle_id();
    endtask

    task automatic test_saturation;
        int n;
        int total;
        do_reset();
        br_taken_i = 1'b1;
        repeat (20) tick();
        br_taken_i = 1'b0;
        #1;
        checks++; if (s_flush_cnt !== 4'd15) begin failures++; $display("FAIL sat_flush got=%0d exp=15", s_flush_cnt); end
        checks++; if (flush_cnt_o !== 16'd20) begin failures++; $display("FAIL wide_flush got=%0d exp=20", flush_cnt_o); end
        do_reset();
        total = 0;
        for (int i = 0; i < 20; i++) begin
            issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, n);
            issue(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, n);
            total += n;
        end
        checks++; if (total !== 20 * LU_STALLS) begin failures++; $display("FAIL sat_total got=%0d exp=%0d", total, 20 * LU_STALLS); end
        checks++; if (stall_cnt_o !== 16'(20 * LU_STALLS)) begin failures++; $display("FAIL wide_stall got=%0d exp=%0d", stall_cnt_o, 20 * LU_STALLS); end
        checks++; if (s_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall got=%0d exp=15", s_stall_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0; br_taken_i = 1'b0; idle_id();
        #2;
        test_reset();
        test_load_use();
        test_forwarding();
        test_r0();
        test_branch();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
